hazard_fwd_unit: RTL
====================

# hazard_fwd_unit

Pipeline control block that drives the select inputs of the execute-stage 3:1 operand forwarding muxes and the stall/flush controls of the fetch/decode registers. Tracks destination-register info for instructions in execute, memory and writeback in its own shadow stage registers, registers the forwarding selects as an instruction enters execute, detects load-use hazards and handles taken-branch flushes.

## Interface
- REG_AW, 5: register-index width.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_d  in  1  decode slot holds a real instruction.
- rs1_d, rs2_d  in  REG_AW  decode-stage source registers.
- rd_d  in  REG_AW  decode-stage destination register.
- regwrite_d  in  1  decode instruction writes rd.
- is_load_d  in  1  decode instruction is a load.
- pcsrc_e  in  1  taken branch/jump resolved in execute.
- fwd_a_e, fwd_b_e  out  2  forwarding selects for operands A/B in execute. Registered.
- stall_f, stall_d  out  1  hold PC and the F/D register. Combinational.
- flush_d, flush_e  out  1  clear the F/D and D/E registers. Combinational.
- stall_cnt, flush_cnt  out  32  event counters, present only with HAZARD_PERF_EN.

## Operation
- Select encoding: 2'b00 register-file value, 2'b01 writeback result, 2'b10 memory-stage ALU result. 2'b11 is never driven.
- Shadow stages E, M, W each hold {valid, rd, regwrite, is_load}.
- Each edge: W<=M and M<=E.
  - E<=decode fields when not stalled and not flushed.
  - Otherwise E<=bubble (valid=0).
- Forwarding is computed per operand on the edge that moves decode into E. It compares rsX_d against the current E, which becomes M next cycle.
  - Match on a valid, regwrite, non-load entry with rd!=0 -> 2'b10.
  - Otherwise, compare against the current M, which becomes W next cycle. Match on a valid, regwrite entry with rd!=0 -> 2'b01.
  - Otherwise -> 2'b00.
  - M has priority over W when both match.
- When E receives a bubble, fwd_a_e and fwd_b_e load 2'b00.
- Load-use stall: lwstall = E.valid & E.is_load & E.rd!=0 & (E.rd==rs1_d | E.rd==rs2_d) & valid_d.
  - stall_f = stall_d = lwstall & ~pcsrc_e.
- Flush: flush_d = pcsrc_e. flush_e = pcsrc_e | lwstall.
- pcsrc_e and lwstall together: the flush wins and the stall is suppressed. This cannot occur legally, and an assertion flags it.
- Register x0 never forwards and never stalls.
- Same-cycle register-file read-after-write for a producer in writeback is handled by the register file, not by this block.

## Timing
- Reset values: all shadow-stage valid bits 0, fwd_a_e = fwd_b_e = 2'b00, stall_f/stall_d/flush_d 0, flush_e = pcsrc_e, counters 0.
- Reset may assert mid-stream; the pipeline restarts empty with no spurious forward.
- Selects change only on clock edges and are stable for the whole execute cycle.
- Stall and flush outputs settle within the same cycle as their inputs. There is no register in that path.
- A load-use pair costs exactly one bubble. The dependent instruction enters execute with select 2'b01.
- A taken branch costs two bubbles (decode and execute slots).

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cnt increments on every cycle where stall_d=1.
  - flush_cnt increments on every cycle where flush_d=1.
  - Both are 32-bit wrapping counters, cleared by rst_n.
- Not defined: the counters and their ports are absent, and the block is otherwise identical.

## Structure
- Package hazard_pkg holds:
  - fwd_sel_t enum: FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - stage_info_t packed struct {valid, rd, regwrite, is_load}.
  - The REG_AW default.
- Sub-module hazard_fwd_cmp is combinational: one source register against E and M info, producing a fwd_sel_t. It is instantiated once per operand.
- The top level holds the shadow stages, the select registers, stall/flush logic and the optional counters.

## Test plan
- Back-to-back ALU chain: add x5 then sub x6,x5,x1. Required: fwd_a_e=2'b10 in the sub's execute cycle, no stall.
- One-gap dependence: add x5; nop; or x7,x1,x5. Required: fwd_b_e=2'b01 in the or's execute cycle.
- Load-use: lw x5; add x6,x5,x5. Required: stall_f=stall_d=flush_e=1 for one cycle, then fwd_a_e=fwd_b_e=2'b01.
- x0 and priority cases:
  - Producers writing x0 never forward: fwd stays 2'b00 and there is no stall.
  - x5 written in both M and W predecessors: the select is 2'b10.
- Branch: pcsrc_e=1 for one cycle. Required: flush_d=flush_e=1, the next execute-cycle selects are 2'b00, and with HAZARD_PERF_EN flush_cnt increments by 1.
- rst_n pulsed low mid load-use stall. Required: stall deasserts immediately, selects read 2'b00, and no forward occurs on the first post-reset instructions.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding unit: select encoding and shadow-stage info.
// No logic, no latency.
// No flow control; pure type definitions.
package hazard_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              is_load;
    } stage_info_t;

endpackage

// File: rtl/hazard_fwd_cmp.sv
// Forwarding select for one source operand against the E and M shadow entries.
// Purely combinational, zero latency.
// No flow control; the caller decides when the result is registered.
module hazard_fwd_cmp
    import hazard_pkg::*;
(
    input  logic [REG_AW-1:0] rs,
    input  stage_info_t       e_info,
    input  stage_info_t       m_info,
    output fwd_sel_t          sel
);

    logic e_hit;
    logic m_hit;

    // E becomes M next cycle, so a non-load hit there is served from the memory-stage ALU
    // result; a load in E is handled by the load-use stall instead. M becomes W next cycle.
    always_comb begin
        e_hit = e_info.valid && e_info.regwrite && !e_info.is_load &&
                (e_info.rd != '0) && (e_info.rd == rs);
        m_hit = m_info.valid && m_info.regwrite &&
                (m_info.rd != '0) && (m_info.rd == rs);
        if (e_hit) begin
            sel = FWD_MEM;
        end else if (m_hit) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Forwarding selects, load-use stall and branch flush control for a 5-stage pipeline.
// Selects registered as decode enters execute (1 cycle); stall/flush combinational (0 cycles).
// A load-use hazard holds F/D one cycle and bubbles E; a taken branch flushes D and E.
// Optional HAZARD_PERF_EN adds 32-bit wrapping stall/flush event counters and their ports.
module hazard_fwd_unit
    import hazard_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_d,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic              regwrite_d,
    input  logic              is_load_d,
    input  logic              pcsrc_e,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
`ifdef HAZARD_PERF_EN
    output logic              flush_e,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`else
    output logic              flush_e
`endif
);

    stage_info_t e_stage;
    stage_info_t m_stage;
    stage_info_t w_stage;
    stage_info_t e_next;
    fwd_sel_t    sel_a;
    fwd_sel_t    sel_b;
    fwd_sel_t    fwd_a_q;
    fwd_sel_t    fwd_b_q;
    logic        lwstall;

    hazard_fwd_cmp u_cmp_a (
        .rs     (rs1_d),
        .e_info (e_stage),
        .m_info (m_stage),
        .sel    (sel_a)
    );

    hazard_fwd_cmp u_cmp_b (
        .rs     (rs2_d),
        .e_info (e_stage),
        .m_info (m_stage),
        .sel    (sel_b)
    );

    // Load-use detection and the resulting stall/flush; a taken branch overrides the stall.
    always_comb begin
        lwstall = valid_d && e_stage.valid && e_stage.is_load && (e_stage.rd != '0) &&
                  ((e_stage.rd == rs1_d) || (e_stage.rd == rs2_d));
        stall_f = lwstall && !pcsrc_e;
        stall_d = lwstall && !pcsrc_e;
        flush_d = pcsrc_e;
        flush_e = pcsrc_e || lwstall;
    end

    // What enters E this edge: the decode instruction, or a bubble when E is being flushed.
    always_comb begin
        e_next          = '0;
        if (!flush_e) begin
            e_next.valid    = valid_d;
            e_next.rd       = rd_d;
            e_next.regwrite = regwrite_d;
            e_next.is_load  = is_load_d;
        end
    end

    // Shadow pipeline advances every edge; bubbles carry valid=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_stage <= '0;
            m_stage <= '0;
            w_stage <= '0;
        end else begin
            e_stage <= e_next;
            m_stage <= e_stage;
            w_stage <= m_stage;
        end
    end

    // Selects follow the instruction into E; a bubble in E reads the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else if (e_next.valid) begin
            fwd_a_q <= sel_a;
            fwd_b_q <= sel_b;
        end else begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end
    end

    assign fwd_a_e = fwd_a_q;
    assign fwd_b_e = fwd_b_q;

`ifdef HAZARD_PERF_EN
    // Event counters: one count per cycle spent stalling decode or flushing decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_d) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush_d) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

    // A taken branch coinciding with a load-use hazard means the upstream pipeline is broken.
    a_no_branch_with_lwstall: assert property (
        @(posedge clk) disable iff (!rst_n) !(pcsrc_e && lwstall)
    ) else $error("taken branch coincided with load-use stall");

    // W carries the retiring producer; its destination must always be a known register.
    a_w_rd_known: assert property (
        @(posedge clk) disable iff (!rst_n) w_stage.valid |-> !$isunknown(w_stage.rd)
    ) else $error("writeback shadow entry has unknown rd");

endmodule
